// File: rtl/i2c_slave_regmap_ctrl.sv
// Sequences the i2c_slave address/data handshakes on the system clock and maps bus bytes onto
// a register-file port with an auto-incrementing pointer loaded by the first written byte.
module i2c_slave_regmap_ctrl #(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter int unsigned PTR_W    = 4,
  parameter logic [7:0]  RD_MISS  = 8'hFF
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [6:0]       SLV_ADDR,
  input  logic             SLV_RW,
  input  logic             SLV_ARDY,
  input  logic             SLV_DRDY,
  input  logic [7:0]       SLV_ODATA,
  output logic [7:0]       SLV_IDATA,
  output logic             SLV_ACKA_RDY,
  output logic             SLV_ACKD_RDY,
  output logic             REG_WE,
  output logic             REG_RE,
  output logic [PTR_W-1:0] REG_ADDR,
  output logic [7:0]       REG_WDATA,
  input  logic [7:0]       REG_RDATA,
  output logic [PTR_W-1:0] PTR,
  output logic             ADDR_HIT
);

  typedef enum logic [2:0] {
    StIdle, StAFetch, StALoad, StAckA, StDEval, StDFetch, StDLoad, StAckD
  } state_e;

  localparam logic [PTR_W-1:0] PtrOne = {{(PTR_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             ardy_m_q, ardy_s_q, ardy_p_q;
  logic             drdy_m_q, drdy_s_q, drdy_p_q;
  logic             rw_q, rw_d;
  logic             hit_q, hit_d;
  logic             first_q, first_d;
  logic [7:0]       odata_q, odata_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       idata_q, idata_d;
  logic             acka_q, acka_d;
  logic             ackd_q, ackd_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic [PTR_W-1:0] raddr_q, raddr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             ev_a, ev_d;

  assign ev_a = ardy_s_q & ~ardy_p_q;
  // Address phase takes priority if both edges ever coincide.
  assign ev_d = drdy_s_q & ~drdy_p_q & ~ev_a;

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    hit_d   = hit_q;
    first_d = first_q;
    odata_d = odata_q;
    ptr_d   = ptr_q;
    idata_d = idata_q;
    acka_d  = acka_q;
    ackd_d  = ackd_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    raddr_d = raddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (ev_a) begin
          rw_d  = SLV_RW;
          hit_d = (SLV_ADDR == DEV_ADDR);
          if (!SLV_RW) begin
            first_d = 1'b1;
            state_d = StAckA;
          end else if (SLV_ADDR == DEV_ADDR) begin
            re_d    = 1'b1;
            raddr_d = ptr_q;
            state_d = StAFetch;
          end else begin
            idata_d = RD_MISS;
            state_d = StAckA;
          end
        end else if (ev_d) begin
          odata_d = SLV_ODATA;
          state_d = StDEval;
        end
      end
      StAFetch: state_d = StALoad;
      StALoad: begin
        idata_d = REG_RDATA;
        ptr_d   = ptr_q + PtrOne;
        state_d = StAckA;
      end
      StAckA: begin
        acka_d = ardy_s_q;
        if (!ardy_s_q) state_d = StIdle;
      end
      StDEval: begin
        state_d = StAckD;
        if (!rw_q) begin
          if (hit_q && first_q) begin
            ptr_d   = odata_q[PTR_W-1:0];
            first_d = 1'b0;
          end else if (hit_q) begin
            we_d    = 1'b1;
            raddr_d = ptr_q;
            wdata_d = odata_q;
            ptr_d   = ptr_q + PtrOne;
          end
        end else if (hit_q) begin
          // Prefetch the byte for the next read data phase.
          re_d    = 1'b1;
          raddr_d = ptr_q;
          state_d = StDFetch;
        end else begin
          idata_d = RD_MISS;
        end
      end
      StDFetch: state_d = StDLoad;
      StDLoad: begin
        idata_d = REG_RDATA;
        ptr_d   = ptr_q + PtrOne;
        state_d = StAckD;
      end
      StAckD: begin
        ackd_d = drdy_s_q;
        if (!drdy_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q  <= StIdle;
      ardy_m_q <= 1'b0;
      ardy_s_q <= 1'b0;
      ardy_p_q <= 1'b0;
      drdy_m_q <= 1'b0;
      drdy_s_q <= 1'b0;
      drdy_p_q <= 1'b0;
      rw_q     <= 1'b0;
      hit_q    <= 1'b0;
      first_q  <= 1'b0;
      odata_q  <= '0;
      ptr_q    <= '0;
      idata_q  <= '0;
      acka_q   <= 1'b0;
      ackd_q   <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      raddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ardy_m_q <= SLV_ARDY;
      ardy_s_q <= ardy_m_q;
      ardy_p_q <= ardy_s_q;
      drdy_m_q <= SLV_DRDY;
      drdy_s_q <= drdy_m_q;
      drdy_p_q <= drdy_s_q;
      rw_q     <= rw_d;
      hit_q    <= hit_d;
      first_q  <= first_d;
      odata_q  <= odata_d;
      ptr_q    <= ptr_d;
      idata_q  <= idata_d;
      acka_q   <= acka_d;
      ackd_q   <= ackd_d;
      we_q     <= we_d;
      re_q     <= re_d;
      raddr_q  <= raddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign SLV_IDATA    = idata_q;
  assign SLV_ACKA_RDY = acka_q;
  assign SLV_ACKD_RDY = ackd_q;
  assign REG_WE       = we_q;
  assign REG_RE       = re_q;
  assign REG_ADDR     = raddr_q;
  assign REG_WDATA    = wdata_q;
  assign PTR          = ptr_q;
  assign ADDR_HIT     = hit_q;

endmodule

// File: tb/tb_i2c_slave_regmap_ctrl.sv
// Bench for i2c_slave_regmap_ctrl: a behavioural slave/register-bank environment plus a
// transaction-level pointer/memory model that predicts every ACK-time value and write.
module tb_i2c_slave_regmap_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic [6:0] slv_addr;
  logic       slv_rw, slv_ardy, slv_drdy;
  logic [7:0] slv_odata, slv_idata;
  logic       acka, ackd;
  logic       reg_we, reg_re;
  logic [3:0] reg_addr, ptr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic       addr_hit;

  i2c_slave_regmap_ctrl dut (
    .CLK(clk), .NRST(nrst), .SLV_ADDR(slv_addr), .SLV_RW(slv_rw), .SLV_ARDY(slv_ardy),
    .SLV_DRDY(slv_drdy), .SLV_ODATA(slv_odata), .SLV_IDATA(slv_idata), .SLV_ACKA_RDY(acka),
    .SLV_ACKD_RDY(ackd), .REG_WE(reg_we), .REG_RE(reg_re), .REG_ADDR(reg_addr),
    .REG_WDATA(reg_wdata), .REG_RDATA(reg_rdata), .PTR(ptr), .ADDR_HIT(addr_hit)
  );

  always #5 clk = ~clk;

  // Register bank: write log, read data one clock after REG_RE.
  logic [7:0]  ram [16];
  logic [11:0] got_wr[$];
  int          n_re_got = 0;
  int          n_both   = 0;

  always @(posedge clk) begin
    if (reg_we) begin
      ram[reg_addr] <= reg_wdata;
      got_wr.push_back({reg_addr, reg_wdata});
    end
    if (reg_re) begin
      reg_rdata <= ram[reg_addr];
      n_re_got  <= n_re_got + 1;
    end
    if (reg_we && reg_re) n_both <= n_both + 1;
  end

  // Reference model state
  logic [7:0]  mem_m [16];
  logic [3:0]  m_ptr   = '0;
  logic        m_first = 1'b0;
  logic        m_hit   = 1'b0;
  logic        m_rw    = 1'b0;
  logic [7:0]  exp_idata;
  logic [11:0] exp_wr[$];
  int          m_re = 0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic wait_ack(input bit is_d, input logic level, input string tag);
    int n = 0;
    while (((is_d ? ackd : acka) !== level) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 100), 32'd1);
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rw, input int hold);
    int lows = 0;
    m_rw    = rw;
    m_hit   = (a == 7'h42);
    m_first = 1'b1;
    if (rw) begin
      if (m_hit) begin
        exp_idata = mem_m[m_ptr];
        m_ptr++;
        m_re++;
      end else begin
        exp_idata = 8'hFF;
      end
    end
    @(negedge clk);
    slv_addr = a;
    slv_rw   = rw;
    slv_ardy = 1'b1;
    wait_ack(1'b0, 1'b1, "acka_rise");
    chk("addr_hit", 32'(addr_hit), 32'(m_hit));
    if (rw) chk("idata_addr", 32'(slv_idata), 32'(exp_idata));
    repeat (hold) begin
      @(negedge clk);
      if (!acka) lows++;
    end
    chk("acka_held", lows, 0);
    slv_ardy = 1'b0;
    wait_ack(1'b0, 1'b0, "acka_fall");
    chk("ptr_addr", 32'(ptr), 32'(m_ptr));
  endtask

  task automatic data_phase(input logic [7:0] d, input int hold);
    if (!m_rw) begin
      if (m_hit && m_first) begin
        m_ptr   = d[3:0];
        m_first = 1'b0;
      end else if (m_hit) begin
        exp_wr.push_back({m_ptr, d});
        mem_m[m_ptr] = d;
        m_ptr++;
      end
    end else if (m_hit) begin
      exp_idata = mem_m[m_ptr];
      m_ptr++;
      m_re++;
    end else begin
      exp_idata = 8'hFF;
    end
    @(negedge clk);
    slv_odata = d;
    slv_drdy  = 1'b1;
    wait_ack(1'b1, 1'b1, "ackd_rise");
    chk("wr_count", got_wr.size(), exp_wr.size());
    if (m_rw) chk("idata_data", 32'(slv_idata), 32'(exp_idata));
    repeat (hold) @(negedge clk);
    slv_drdy = 1'b0;
    wait_ack(1'b1, 1'b0, "ackd_fall");
    chk("ptr_data", 32'(ptr), 32'(m_ptr));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int re0;
    logic [6:0] ra;
    nrst      = 1'b0;
    slv_addr  = '0;
    slv_rw    = 1'b0;
    slv_ardy  = 1'b0;
    slv_drdy  = 1'b0;
    slv_odata = '0;
    for (int i = 0; i < 16; i++) begin
      ram[i]   = 8'($urandom);
      mem_m[i] = ram[i];
    end
    ram[3] = 8'h11; mem_m[3] = 8'h11;
    ram[4] = 8'h22; mem_m[4] = 8'h22;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({slv_idata, acka, ackd, reg_we, reg_re, reg_addr, reg_wdata, ptr,
                              addr_hit}), 32'd0);
    nrst = 1'b1;

    // Pointer 5, then two register writes.
    addr_phase(7'h42, 1'b0, 2);
    data_phase(8'h05, 1);
    data_phase(8'hA1, 0);
    data_phase(8'hB2, 3);
    chk("t1_ptr", 32'(ptr), 32'd7);

    // Pointer 3, then read two bytes.
    addr_phase(7'h42, 1'b0, 1);
    data_phase(8'h03, 1);
    addr_phase(7'h42, 1'b1, 2);
    chk("t2_first_byte", 32'(slv_idata), 32'h11);
    data_phase(8'h00, 2);
    chk("t2_second_byte", 32'(slv_idata), 32'h22);
    chk("t2_ptr", 32'(ptr), 32'd5);

    // Foreign address: writes dropped, reads return the miss byte.
    addr_phase(7'h10, 1'b0, 1);
    data_phase(8'h01, 1);
    data_phase(8'h55, 1);
    addr_phase(7'h10, 1'b1, 1);
    chk("t3_miss_byte", 32'(slv_idata), 32'hFF);

    // Pointer wrap, then an over-wide pointer byte.
    addr_phase(7'h42, 1'b0, 0);
    data_phase(8'h0F, 0);
    data_phase(8'hC1, 0);
    data_phase(8'hC2, 0);
    data_phase(8'hC3, 0);
    chk("t4_wrap_ptr", 32'(ptr), 32'd2);
    addr_phase(7'h42, 1'b0, 0);
    data_phase(8'h3C, 0);
    chk("t4_trunc_ptr", 32'(ptr), 32'hC);
    data_phase(8'h9D, 0);

    // Reset while the address ACK is held.
    @(negedge clk);
    slv_addr = 7'h42;
    slv_rw   = 1'b1;
    slv_ardy = 1'b1;
    m_re++;
    wait_ack(1'b0, 1'b1, "t5_acka_rise");
    #2 nrst = 1'b0;
    #1 chk("t5_async_reset", 32'({slv_idata, acka, ackd, reg_we, reg_re, reg_addr, reg_wdata,
                                  ptr, addr_hit}), 32'd0);
    slv_ardy = 1'b0;
    m_ptr    = '0;
    m_first  = 1'b0;
    m_hit    = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    addr_phase(7'h42, 1'b0, 1);
    data_phase(8'h02, 1);
    data_phase(8'h77, 1);

    // Slow master holding ARDY for 50 clocks.
    re0 = n_re_got;
    addr_phase(7'h42, 1'b1, 50);
    chk("t6_single_re", n_re_got - re0, 1);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      int nb;
      ra = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom_range(0, 127));
      nb = $urandom_range(1, 4);
      addr_phase(ra, 1'($urandom_range(0, 1)), $urandom_range(0, 6));
      for (int b = 0; b < nb; b++) data_phase(8'($urandom), $urandom_range(0, 6));
    end

    repeat (4) @(negedge clk);
    chk("total_writes", got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) chk("write_entry", 32'(got_wr[i]),
                                                                     32'(exp_wr[i]));
    chk("read_strobes", n_re_got, m_re);
    chk("we_re_overlap", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
